mult_seq_ctrl: RTL

MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

---
 rtl/mult_pkg.sv | 28 ++
 rtl/shift_add_step.sv | 21 ++
 rtl/mult_seq_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared types and width helpers for the sequential shift-add multiplier.
// Build option: MULT_ZERO_SKIP_EN (see mult_seq_ctrl.sv) ends a product early
// once the remaining multiplier bits are all zero.
package mult_pkg;

    // Controller states: accept operands, iterate over multiplier bits, present result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Default operand width and the widths that follow from it.
    localparam int DEFAULT_W      = 7;
    localparam int DEFAULT_PROD_W = 2 * DEFAULT_W;
    localparam int DEFAULT_CNT_W  = $clog2(DEFAULT_W + 1);

    // Product width for operand width w; the product of two w-bit values always fits.
    function automatic int prod_width(input int w);
        return 2 * w;
    endfunction

    // Counter width able to hold 0..w (adder activations, bit index).
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/shift_add_step.sv
// One accumulate step of the shift-add multiplier: acc + operand when enabled,
// otherwise acc passes through unchanged. Purely combinational; the caller owns
// all state and keeps the operand steady on idle steps.
module shift_add_step #(
    parameter int PW = 14
) (
    input  logic [PW-1:0] acc,
    input  logic [PW-1:0] operand,
    input  logic          en,
    output logic [PW-1:0] acc_next
);

    logic [PW-1:0] sum;

    // Full-width add; the product never exceeds PW bits, so no carry-out is kept.
    always_comb begin
        sum      = acc + operand;
        acc_next = en ? sum : acc;
    end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequential unsigned multiplier with valid/ready handshakes on both sides.
// One multiplier bit is consumed per RUN cycle; a set bit adds the shifted
// multiplicand into a 2W-bit accumulator and bumps add_count.
// Build option MULT_ZERO_SKIP_EN: RUN ends as soon as no set multiplier bits
// remain (at least one cycle). Without it RUN always lasts W cycles.
module mult_seq_ctrl
    import mult_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [W-1:0]                a,
    input  logic [W-1:0]                b,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [prod_width(W)-1:0]    result,
    output logic [cnt_width(W)-1:0]     add_count
);

    localparam int PW = prod_width(W);
    localparam int CW = cnt_width(W);

    state_t         state_reg;
    logic [W-1:0]   b_reg;
    logic [PW-1:0]  a_shift_reg;
    logic [PW-1:0]  op_hold_reg;
    logic [PW-1:0]  acc_reg;
    logic [PW-1:0]  result_reg;
    logic [CW-1:0]  idx_reg;
    logic [CW-1:0]  add_count_reg;
    logic           in_ready_reg;
    logic           out_valid_reg;

    logic           add_en;
    logic [PW-1:0]  add_operand;
    logic [PW-1:0]  acc_next;
    logic [W-1:0]   b_shifted;
    logic [CW-1:0]  count_next;
    logic           last_step;

    // Step control: on a zero multiplier bit the adder sees the operand it last
    // used, so neither adder input changes and the accumulator keeps its value.
    always_comb begin
        add_en      = b_reg[0];
        add_operand = add_en ? a_shift_reg : op_hold_reg;
        b_shifted   = b_reg >> 1;
        count_next  = add_count_reg + {{(CW-1){1'b0}}, add_en};
`ifdef MULT_ZERO_SKIP_EN
        last_step   = (b_shifted == '0);
`else
        last_step   = (idx_reg == CW'(W - 1));
`endif
    end

    shift_add_step #(
        .PW (PW)
    ) u_step (
        .acc      (acc_reg),
        .operand  (add_operand),
        .en       (add_en),
        .acc_next (acc_next)
    );

    // Controller FSM with registered handshake outputs and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            b_reg         <= '0;
            a_shift_reg   <= '0;
            op_hold_reg   <= '0;
            acc_reg       <= '0;
            result_reg    <= '0;
            idx_reg       <= '0;
            add_count_reg <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid && in_ready_reg) begin
                        a_shift_reg   <= {{W{1'b0}}, a};
                        b_reg         <= b;
                        op_hold_reg   <= '0;
                        acc_reg       <= '0;
                        idx_reg       <= '0;
                        add_count_reg <= '0;
                        in_ready_reg  <= 1'b0;
                        state_reg     <= RUN;
                    end
                end
                RUN: begin
                    if (add_en) begin
                        acc_reg     <= acc_next;
                        op_hold_reg <= a_shift_reg;
                    end
                    add_count_reg <= count_next;
                    b_reg         <= b_shifted;
                    a_shift_reg   <= a_shift_reg << 1;
                    idx_reg       <= idx_reg + 1'b1;
                    if (last_step) begin
                        result_reg    <= acc_next;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign add_count = add_count_reg;

endmodule
